kernel_bram_loader: RTL and testbench

//  Write-side filler for the 3x3 conv kernel BRAM. Accepts a stream of KERNEL_WIDTH-bit weights,

---
 rtl/kernel_bram_loader.sv | 126 ++++++++++++
 tb/tb_kernel_bram_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_bram_loader.sv
// Packs TAPS streamed weights per channel into one word and writes it to kernel BRAM port A.
// Optional tlast checking is enabled by defining KERNEL_LOADER_TLAST_CHECK_EN.
module kernel_bram_loader #(
  parameter int unsigned KERNEL_WIDTH = 16,
  parameter int unsigned TAPS         = 9,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          num_channels,
  input  logic [KERNEL_WIDTH-1:0]      s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic                         ena_kernel_BRAM,
  output logic                         wea_kernel_BRAM,
  output logic [ADDR_WIDTH-1:0]        kernel_BRAM_addra,
  output logic [TAPS*KERNEL_WIDTH-1:0] kernel_BRAM_dina,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned WORD_W = TAPS * KERNEL_WIDTH;
  localparam int unsigned TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned NCH_W  = ADDR_WIDTH + 1;
  localparam logic [NCH_W-1:0] MAX_CH = NCH_W'(1 << ADDR_WIDTH);

`ifdef KERNEL_LOADER_TLAST_CHECK_EN
  localparam bit TLAST_CHECK_EN = 1'b1;
`else
  localparam bit TLAST_CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t                                 state, state_next;
  logic [TAP_W-1:0]                       tap_cnt;
  logic [ADDR_WIDTH-1:0]                  ch_cnt;
  logic [ADDR_WIDTH-1:0]                  last_ch;
  logic [TAPS-2:0][KERNEL_WIDTH-1:0]      pack;

  logic                                   accept_c;
  logic                                   word_end_c;
  logic                                   final_beat_c;
  logic                                   early_abort_c;
  logic                                   tlast_missing_c;
  logic [NCH_W-1:0]                       nch_sat_c;

  // Handshake decode and next-state logic
  always_comb begin
    nch_sat_c       = (num_channels > MAX_CH) ? MAX_CH : num_channels;
    accept_c        = s_axis_tready & s_axis_tvalid;
    word_end_c      = accept_c && (tap_cnt == TAP_W'(TAPS - 1));
    final_beat_c    = word_end_c && (ch_cnt == last_ch);
    early_abort_c   = TLAST_CHECK_EN && accept_c && s_axis_tlast && !final_beat_c;
    tlast_missing_c = TLAST_CHECK_EN && final_beat_c && !s_axis_tlast;
    state_next      = state;
    case (state)
      IDLE:    if (start) state_next = (num_channels == '0) ? DONE : LOAD;
      LOAD: begin
        if (early_abort_c)     state_next = DONE;
        else if (final_beat_c) state_next = FLUSH;
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Packing datapath and registered outputs; status flags follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt           <= '0;
      ch_cnt            <= '0;
      last_ch           <= '0;
      pack              <= '0;
      s_axis_tready     <= 1'b0;
      ena_kernel_BRAM   <= 1'b0;
      wea_kernel_BRAM   <= 1'b0;
      kernel_BRAM_addra <= '0;
      kernel_BRAM_dina  <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      ena_kernel_BRAM <= 1'b0;
      wea_kernel_BRAM <= 1'b0;
      s_axis_tready   <= (state_next == LOAD);
      busy            <= (state_next == LOAD) || (state_next == FLUSH);
      done            <= (state_next == DONE);

      if (state == IDLE && start) begin
        tap_cnt <= '0;
        ch_cnt  <= '0;
        last_ch <= ADDR_WIDTH'(nch_sat_c - 1'b1);
        err     <= 1'b0;
      end

      if (early_abort_c || tlast_missing_c) err <= 1'b1;

      if (accept_c && !early_abort_c) begin
        if (word_end_c) begin
          ena_kernel_BRAM   <= 1'b1;
          wea_kernel_BRAM   <= 1'b1;
          kernel_BRAM_addra <= ch_cnt;
          kernel_BRAM_dina  <= WORD_W'({s_axis_tdata, pack});
          tap_cnt           <= '0;
          ch_cnt            <= ch_cnt + 1'b1;
        end else begin
          for (int k = 0; k < int'(TAPS) - 1; k++) begin
            if (tap_cnt == TAP_W'(k)) pack[k] <= s_axis_tdata;
          end
          tap_cnt <= tap_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_bram_loader.sv
// Scoreboard bench for kernel_bram_loader: expected BRAM writes are queued as beats are driven
// and checked by a negedge monitor whenever port A is enabled.
module tb_kernel_bram_loader;

  localparam int unsigned KW   = 16;
  localparam int unsigned TAPS = 9;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = KW * TAPS;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_channels;
  logic [KW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          ena_kernel_BRAM;
  logic          wea_kernel_BRAM;
  logic [AW-1:0] kernel_BRAM_addra;
  logic [DW-1:0] kernel_BRAM_dina;
  logic          busy;
  logic          done;
  logic          err;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  done_cnt, hs_cnt, busy_cnt, ena_cnt, tready_cnt;
  int  first_hs_cyc, last_hs_cyc, last_ena_cyc, last_done_cyc;

  always #5 clk = ~clk;

  kernel_bram_loader #(.KERNEL_WIDTH(KW), .TAPS(TAPS), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .num_channels      (num_channels),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .ena_kernel_BRAM   (ena_kernel_BRAM),
    .wea_kernel_BRAM   (wea_kernel_BRAM),
    .kernel_BRAM_addra (kernel_BRAM_addra),
    .kernel_BRAM_dina  (kernel_BRAM_dina),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    done_cnt = 0; hs_cnt = 0; busy_cnt = 0; ena_cnt = 0; tready_cnt = 0;
    first_hs_cyc = 0; last_hs_cyc = 0; last_ena_cyc = 0; last_done_cyc = 0;
  endtask

  // Observes port A at negedge and compares every write against the scoreboard
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (s_axis_tvalid && s_axis_tready) begin
        if (hs_cnt == 0) first_hs_cyc = cyc;
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (s_axis_tready) tready_cnt++;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (ena_kernel_BRAM) begin
        ena_cnt++;
        last_ena_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d dina=%h", kernel_BRAM_addra, kernel_BRAM_dina);
        end else begin
          e = exp_q.pop_front();
          if (kernel_BRAM_addra !== e.addr || kernel_BRAM_dina !== e.data || wea_kernel_BRAM !== 1'b1) begin
            errors++;
            $display("FAIL write addr=%0d dina=%h wea=%b, expected addr=%0d dina=%h wea=1",
                     kernel_BRAM_addra, kernel_BRAM_dina, wea_kernel_BRAM, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_channels = (AW+1)'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [KW-1:0] d, input bit last, input bit gaps);
    int budget;
    bit hs;
    if (gaps && $urandom_range(0, 1) == 1) begin
      s_axis_tvalid = 1'b0;
      step();
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      hs = s_axis_tready;
      step();
      if (hs) break;
      budget++;
      if (budget > 50) begin
        checks++; errors++;
        $display("FAIL beat_timeout data=%h tready=%b expected 1", d, s_axis_tready);
        break;
      end
    end
  endtask

  // Drives nbeats beats (data = base+index+1); tlast at tlast_idx; start re-pulsed at start_at
  task automatic send_channels(input int base, input bit gaps, input int tlast_idx,
                               input int nbeats, input int start_at, input bit push);
    logic [DW-1:0] word;
    logic [KW-1:0] d;
    int c, j;
    wr_t e;
    word = '0;
    for (int g = 0; g < nbeats; g++) begin
      c = g / TAPS;
      j = g % TAPS;
      d = KW'(base + g + 1);
      word[j*KW +: KW] = d;
      if (j == TAPS - 1 && push) begin
        e.addr = AW'(c);
        e.data = word;
        exp_q.push_back(e);
      end
      if (g == start_at) begin start = 1'b1; num_channels = (AW+1)'(1); end
      send_beat(d, (g == tlast_idx), gaps);
      start = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout done_cnt=%0d expected >0", done_cnt);
    end
    step();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({ena_kernel_BRAM, wea_kernel_BRAM, s_axis_tready, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b expected 000000",
               {ena_kernel_BRAM, wea_kernel_BRAM, s_axis_tready, busy, done, err});
    end
    checks++;
    if (kernel_BRAM_addra !== '0 || kernel_BRAM_dina !== '0) begin
      errors++;
      $display("FAIL reset_port addra=%0d dina=%h expected 0", kernel_BRAM_addra, kernel_BRAM_dina);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    clear_stats();
    do_start(1);
    send_channels(0, 1'b0, TAPS - 1, TAPS, -1, 1'b1);
    wait_done(20);
    check_int("single_writes", ena_cnt, 1);
    check_int("single_write_latency", last_ena_cyc - last_hs_cyc, 1);
    check_int("single_done_latency", last_done_cyc - last_ena_cyc, 1);
    check_int("single_tready_cycles", tready_cnt, TAPS);
    check_int("single_done_count", done_cnt, 1);
  endtask

  task automatic test_full(input int n_req, input int n_exp);
    clear_stats();
    do_start(n_req);
    send_channels(16'h1000, 1'b0, n_exp * TAPS - 1, n_exp * TAPS, -1, 1'b1);
    wait_done(20);
    check_int("full_writes", ena_cnt, n_exp);
    check_int("full_beats", hs_cnt, n_exp * TAPS);
    check_int("full_no_stall", last_hs_cyc - first_hs_cyc, n_exp * TAPS - 1);
    check_int("full_busy_cycles", busy_cnt, n_exp * TAPS + 1);
    check_int("full_done_count", done_cnt, 1);
    check_int("full_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_gaps();
    clear_stats();
    do_start(2);
    send_channels(16'h0100, 1'b1, 2 * TAPS - 1, 2 * TAPS, -1, 1'b1);
    wait_done(20);
    check_int("gaps_writes", ena_cnt, 2);
    check_int("gaps_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid_load();
    clear_stats();
    do_start(1);
    send_channels(16'h0050, 1'b0, -1, 5, -1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_int("midrst_no_write", ena_cnt, 0);
    check_int("midrst_idle", {30'd0, busy, s_axis_tready}, 0);
    clear_stats();
    do_start(1);
    send_channels(16'h0200, 1'b0, TAPS - 1, TAPS, -1, 1'b1);
    wait_done(20);
    check_int("midrst_restart_writes", ena_cnt, 1);
    check_int("midrst_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_start_ignored();
    clear_stats();
    do_start(2);
    send_channels(16'h0300, 1'b0, 2 * TAPS - 1, 2 * TAPS, 3, 1'b1);
    wait_done(20);
    check_int("busy_start_writes", ena_cnt, 2);
    check_int("busy_start_done", done_cnt, 1);
    clear_stats();
    do_start(0);
    check_int("zero_done_high", {31'd0, done}, 1);
    step();
    check_int("zero_done_low", {31'd0, done}, 0);
    check_int("zero_no_write", ena_cnt, 0);
    check_int("zero_no_busy", busy_cnt, 0);
  endtask

  task automatic test_tlast();
    clear_stats();
    do_start(1);
`ifdef KERNEL_LOADER_TLAST_CHECK_EN
    send_channels(16'h0400, 1'b0, 4, 5, -1, 1'b0);
    wait_done(20);
    check_int("tlast_err", {31'd0, err}, 1);
    check_int("tlast_no_write", ena_cnt, 0);
    check_int("tlast_done", done_cnt, 1);
    do_start(0);
    check_int("tlast_err_cleared", {31'd0, err}, 0);
    step();
`else
    send_channels(16'h0400, 1'b0, 4, TAPS, -1, 1'b1);
    wait_done(20);
    check_int("tlast_err", {31'd0, err}, 0);
    check_int("tlast_write", ena_cnt, 1);
`endif
    check_int("tlast_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_channels = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    clear_stats();
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_full(256, 256);
    test_full(511, 256);
    test_gaps();
    test_reset_mid_load();
    test_start_ignored();
    test_tlast();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
